// File: rtl/x10_uart_tx.sv
// Serial console: queues the low byte of x10 on every value change, sends 8N1 frames on tx.
// Latency: x10 change -> tx start bit falls 2 cycles later; frame pitch 10*CLKS_PER_BIT+1.
// Backpressure: none upstream; a change seen while the queue is full is dropped and sets sticky overflow.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   x10        processor x10 register value, sampled every cycle
//   tx         UART serial output, idle high, driven from a flop
//   busy       frame in flight or queue non-empty
//   overflow   sticky: a byte was dropped because the queue was full
//   fifo_count queued bytes, excluding the frame in flight
module x10_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   x10,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [31:0]   x10_prev_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          overflow_q;

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] baud_q,    baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic          tx_q,      tx_d;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          baud_end;
    logic [AW:0]   count;

    // Pointers are one bit wider than the index, so the difference is the
    // occupancy and full/empty are distinguishable without a separate flag.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // Full 32-bit compare: a change only in the upper bits still sends the low byte.
    assign push_req = (x10 != x10_prev_q);
    // Pop only from a non-empty queue, so a push into an empty queue is never bypassed.
    assign pop      = (state_q == S_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full queue survives.
    assign push     = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x10_prev_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            x10_prev_q <= x10;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= x10[7:0];
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d is the level for the next cycle, so tx changes exactly on the
    // edge where the FSM enters the corresponding bit.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // shift_q[1] is the bit that lands in [0] after this shift.
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign overflow   = overflow_q;
    assign fifo_count = count;

endmodule
